// File: rtl/stack_if.sv
// stack_if: request/response handshake plus register-bank and data-memory buses of the stack unit
interface stack_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  ready;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [ADDR_WIDTH-1:0] rb_r_addr;
    logic [DATA_WIDTH-1:0] rb_busB;
    logic                  rb_w_en;
    logic [ADDR_WIDTH-1:0] rb_w_addr;
    logic [DATA_WIDTH-1:0] rb_w_data;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output push, pop, push_data, rb_busB, mem_rdata,
        input  ready, done, err, pop_data, rb_r_addr, rb_w_en, rb_w_addr, rb_w_data,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  push, pop, push_data, rb_busB, mem_rdata,
        output ready, done, err, pop_data, rb_r_addr, rb_w_en, rb_w_addr, rb_w_data,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: push/pop sequencer reading SP from the register bank, accessing data memory and writing SP/ACC back
module stack_unit #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0] SP_ADDR     = 3'd1,
    parameter logic [ADDR_WIDTH-1:0] ACC_ADDR    = 3'd7,
    parameter logic [DATA_WIDTH-1:0] STACK_FLOOR = 8'h80
) (
    input  logic   clk,
    input  logic   rst_n,
    stack_if.slave sif
);
    typedef enum logic [2:0] {IDLE, RD_SP, PUSH_WR, POP_RD, POP_WAIT, POP_WB, FIN} state_t;
    localparam logic [DATA_WIDTH-1:0] EMPTY = '1;
    state_t                r_state, w_next;
    logic                  r_op, r_err;
    logic [DATA_WIDTH-1:0] r_data, r_sp, r_pop_data;
    logic                  w_rd_err;
    // Full/empty is judged on the live bank value so no SP update can ever wrap
    assign w_rd_err = r_op ? (sif.rb_busB == STACK_FLOOR) : (sif.rb_busB == EMPTY);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = (sif.push || sif.pop) ? RD_SP : IDLE;
            RD_SP:    w_next = w_rd_err ? FIN : (r_op ? PUSH_WR : POP_RD);
            PUSH_WR:  w_next = FIN;
            POP_RD:   w_next = POP_WAIT;
            POP_WAIT: w_next = POP_WB;
            POP_WB:   w_next = FIN;
            FIN:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
            r_sp       <= '0;
            r_pop_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (sif.push || sif.pop)) begin
                r_op   <= sif.push;
                r_data <= sif.push ? sif.push_data : r_data;
            end
            if (r_state == RD_SP) begin
                r_sp  <= sif.rb_busB;
                r_err <= w_rd_err;
            end
            if (r_state == FIN) r_err <= 1'b0;
            if (r_state == POP_WAIT) r_pop_data <= sif.mem_rdata;
        end
    end
    assign sif.ready     = r_state == IDLE;
    assign sif.done      = r_state == FIN;
    assign sif.err       = r_state == FIN && r_err;
    assign sif.pop_data  = r_pop_data;
    assign sif.rb_r_addr = r_state == RD_SP ? SP_ADDR : '0;
    assign sif.rb_w_en   = r_state == PUSH_WR || r_state == POP_RD || r_state == POP_WB;
    assign sif.rb_w_addr = r_state == POP_WB ? ACC_ADDR :
                           (r_state == PUSH_WR || r_state == POP_RD) ? SP_ADDR : '0;
    assign sif.rb_w_data = r_state == PUSH_WR ? r_sp - 1'b1 :
                           r_state == POP_RD  ? r_sp + 1'b1 :
                           r_state == POP_WB  ? r_pop_data : '0;
    assign sif.mem_addr  = r_state == PUSH_WR ? r_sp :
                           r_state == POP_RD  ? r_sp + 1'b1 : '0;
    assign sif.mem_we    = r_state == PUSH_WR;
    assign sif.mem_wdata = r_state == PUSH_WR ? r_data : '0;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: bank/memory models around stack_unit with a scoreboard of expected completions
module tb_stack_unit;
    typedef struct {
        logic       err;
        logic [7:0] pd;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_if sif ();
    stack_unit dut (.clk(clk), .rst_n(rst_n), .sif(sif));

    logic [7:0]  bank [8];
    logic [7:0]  mem [256];
    logic [7:0]  rdata;
    logic        preload_en = 1'b0;
    logic [7:0]  preload_val = 8'h00;
    logic [10:0] bw_log [$];
    logic [15:0] mw_log [$];
    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;

    assign sif.rb_busB   = bank[sif.rb_r_addr];
    assign sif.mem_rdata = rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) bank[i] <= (i == 1) ? 8'hFF : 8'h00;
            rdata <= 8'h00;
        end else begin
            if (preload_en) bank[1] <= preload_val;
            else if (sif.rb_w_en) begin
                bank[sif.rb_w_addr] <= sif.rb_w_data;
                bw_log.push_back({sif.rb_w_addr, sif.rb_w_data});
            end
            if (sif.mem_we) begin
                mem[sif.mem_addr] <= sif.mem_wdata;
                mw_log.push_back({sif.mem_addr, sif.mem_wdata});
            end
            rdata <= mem[sif.mem_addr];
        end
    end

    task automatic set_sp(input logic [7:0] v);
        @(negedge clk);
        preload_en = 1'b1;
        preload_val = v;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    // Drives one request at edge E and reports the cycle offset of done (-1 on timeout)
    task automatic run_op(input logic p, input logic q, input logic [7:0] d, input logic hold_pop,
                          output int lat, output logic e);
        @(negedge clk);
        sif.push = p;
        sif.pop = q;
        sif.push_data = d;
        @(posedge clk);
        #1;
        sif.push = 1'b0;
        sif.pop = hold_pop;
        lat = -1;
        e = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sif.done) begin
                lat = k;
                e = sif.err;
                break;
            end
        end
        sif.pop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 8;
        if (sif.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", sif.ready); end
        if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", sif.done); end
        if (sif.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", sif.err); end
        if (sif.rb_w_en !== 1'b0) begin errors++; $display("FAIL reset_rb_w_en got=%b exp=0", sif.rb_w_en); end
        if (sif.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", sif.mem_we); end
        if (sif.pop_data !== 8'h00) begin errors++; $display("FAIL reset_pop_data got=%h exp=00", sif.pop_data); end
        if (sif.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h exp=00", sif.mem_addr); end
        if (sif.rb_r_addr !== 3'd0) begin errors++; $display("FAIL reset_rb_r_addr got=%h exp=0", sif.rb_r_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_push();
        int lat, b, m;
        logic e;
        exp_t x;
        b = bw_log.size();
        m = mw_log.size();
        sb.push_back('{1'b0, 8'h00, 3});
        run_op(1'b1, 1'b0, 8'hA5, 1'b0, lat, e);
        x = sb.pop_front();
        checks += 5;
        if (lat !== x.lat) begin errors++; $display("FAIL push_latency got=%0d exp=%0d", lat, x.lat); end
        if (e !== x.err) begin errors++; $display("FAIL push_err got=%b exp=%b", e, x.err); end
        if (sif.pop_data !== x.pd) begin errors++; $display("FAIL push_pop_data got=%h exp=%h", sif.pop_data, x.pd); end
        if (bw_log.size() != b + 1 || bw_log[b] !== {3'd1, 8'hFE})
            begin errors++; $display("FAIL push_bank_write n=%0d got=%h exp=1fe", bw_log.size() - b, bw_log[b]); end
        if (mw_log.size() != m + 1 || mw_log[m] !== 16'hFFA5)
            begin errors++; $display("FAIL push_mem_write n=%0d got=%h exp=ffa5", mw_log.size() - m, mw_log[m]); end
    endtask

    task automatic test_push_pop();
        logic       is_push [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] dat [4]     = '{8'h11, 8'h22, 8'h00, 8'h00};
        logic [7:0] exp_sp [4]  = '{8'hFE, 8'hFD, 8'hFE, 8'hFF};
        logic [7:0] exp_pd [4]  = '{8'h00, 8'h00, 8'h22, 8'h11};
        int lat;
        logic e;
        exp_t x;
        set_sp(8'hFF);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b0, exp_pd[i], is_push[i] ? 3 : 5});
            run_op(is_push[i], !is_push[i], dat[i], 1'b0, lat, e);
            x = sb.pop_front();
            checks += 4;
            if (lat !== x.lat) begin errors++; $display("FAIL seq%0d_latency got=%0d exp=%0d", i, lat, x.lat); end
            if (e !== x.err) begin errors++; $display("FAIL seq%0d_err got=%b exp=%b", i, e, x.err); end
            if (sif.pop_data !== x.pd) begin errors++; $display("FAIL seq%0d_pop_data got=%h exp=%h", i, sif.pop_data, x.pd); end
            if (bank[1] !== exp_sp[i]) begin errors++; $display("FAIL seq%0d_sp got=%h exp=%h", i, bank[1], exp_sp[i]); end
            if (!is_push[i]) begin
                checks++;
                if (bank[7] !== x.pd) begin errors++; $display("FAIL seq%0d_acc got=%h exp=%h", i, bank[7], x.pd); end
            end
        end
    endtask

    task automatic test_error(input logic is_push, input logic [7:0] sp, input logic [7:0] pd);
        int lat, b, m;
        logic e;
        exp_t x;
        set_sp(sp);
        b = bw_log.size();
        m = mw_log.size();
        sb.push_back('{1'b1, pd, 2});
        run_op(is_push, !is_push, 8'h5A, 1'b0, lat, e);
        x = sb.pop_front();
        checks += 5;
        if (lat !== x.lat) begin errors++; $display("FAIL err%b_latency got=%0d exp=%0d", is_push, lat, x.lat); end
        if (e !== x.err) begin errors++; $display("FAIL err%b_err got=%b exp=%b", is_push, e, x.err); end
        if (sif.pop_data !== x.pd) begin errors++; $display("FAIL err%b_pop_data got=%h exp=%h", is_push, sif.pop_data, x.pd); end
        if (bw_log.size() != b) begin errors++; $display("FAIL err%b_bank_writes got=%0d exp=0", is_push, bw_log.size() - b); end
        if (mw_log.size() != m) begin errors++; $display("FAIL err%b_mem_writes got=%0d exp=0", is_push, mw_log.size() - m); end
        set_sp(8'hFF);
    endtask

    task automatic test_simultaneous();
        int lat, m, extra;
        logic e;
        exp_t x;
        m = mw_log.size();
        sb.push_back('{1'b0, 8'h11, 3});
        run_op(1'b1, 1'b1, 8'h3C, 1'b1, lat, e);
        x = sb.pop_front();
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (sif.done) extra++;
        end
        checks += 6;
        if (lat !== x.lat) begin errors++; $display("FAIL simul_latency got=%0d exp=%0d", lat, x.lat); end
        if (e !== x.err) begin errors++; $display("FAIL simul_err got=%b exp=%b", e, x.err); end
        if (bank[1] !== 8'hFE) begin errors++; $display("FAIL simul_sp got=%h exp=fe", bank[1]); end
        if (mw_log.size() != m + 1 || mw_log[m] !== 16'hFF3C)
            begin errors++; $display("FAIL simul_mem_write n=%0d got=%h exp=ff3c", mw_log.size() - m, mw_log[m]); end
        if (extra != 0) begin errors++; $display("FAIL simul_extra_done got=%0d exp=0", extra); end
        if (sif.ready !== 1'b1) begin errors++; $display("FAIL simul_ready got=%b exp=1", sif.ready); end
    endtask

    task automatic test_reset_mid();
        int b, dn;
        @(negedge clk);
        sif.pop = 1'b1;
        @(posedge clk);
        #1 sif.pop = 1'b0;
        repeat (3) @(negedge clk);
        b = bw_log.size();
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (sif.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", sif.ready); end
        if (sif.rb_w_en !== 1'b0) begin errors++; $display("FAIL midrst_rb_w_en got=%b exp=0", sif.rb_w_en); end
        if (sif.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", sif.done); end
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (sif.done) dn++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (sif.done) dn++;
        end
        checks += 4;
        if (dn != 0) begin errors++; $display("FAIL midrst_done_pulses got=%0d exp=0", dn); end
        if (bw_log.size() != b) begin errors++; $display("FAIL midrst_acc_write got=%0d exp=0", bw_log.size() - b); end
        if (sif.pop_data !== 8'h00) begin errors++; $display("FAIL midrst_pop_data got=%h exp=00", sif.pop_data); end
        if (bank[1] !== 8'hFF) begin errors++; $display("FAIL midrst_sp got=%h exp=ff", bank[1]); end
    endtask

    initial begin
        sif.push = 1'b0;
        sif.pop = 1'b0;
        sif.push_data = 8'h00;
        test_reset();
        test_push();
        test_push_pop();
        test_error(1'b0, 8'hFF, 8'h11);
        test_error(1'b1, 8'h80, 8'h11);
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stack_unit.md
# stack_unit

Push/pop sequencer that sits directly in front of the 8-entry register bank's write port. It reads SP over the bank's busB, issues the data-memory access, and writes the updated SP back through the bank's write port. On a pop it also writes the popped byte into ACC. The stack grows downward from SP = 8'hFF toward a configurable floor; only one operation is in flight at a time, under a ready/done handshake.

## Interface
- DATA_WIDTH, 8, data and memory-address width
- ADDR_WIDTH, 3, register-bank address width
- SP_ADDR, 3'd1, bank index of SP
- ACC_ADDR, 3'd7, bank index of ACC
- STACK_FLOOR, 8'h80, SP value at which the stack is full

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  push request, sampled only when ready=1
- pop  in  1  pop request, sampled only when ready=1
- push_data  in  DATA_WIDTH  byte to push, captured at acceptance
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse at end of every accepted op, including errored ones
- err  out  1  one-cycle pulse with done; overflow on push, underflow on pop
- pop_data  out  DATA_WIDTH  last popped byte, held until next successful pop
- rb_r_addr  out  ADDR_WIDTH  bank read address
- rb_busB  in  DATA_WIDTH  bank read data (combinational from rb_r_addr)
- rb_w_en / rb_w_addr / rb_w_data  out  1 / ADDR_WIDTH / DATA_WIDTH  bank write port
- mem_addr  out  DATA_WIDTH  data-memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  synchronous-read data, valid in the cycle after the address is presented

## Operation
- **State:** state (IDLE, RD_SP, PUSH_WR, POP_RD, POP_WAIT, POP_WB, FIN), op flag, data_q, sp_q, err_q, pop_data.
- **Reset values:** state=IDLE, sp_q=0, data_q=0, pop_data=0.
- **Outputs during/after reset:** ready=1, done=0, err=0, rb_w_en=0, mem_we=0. All addresses and write-data outputs are 0.
- **IDLE:**
  - push=1 accepts a push, captures push_data into data_q, and goes to RD_SP.
  - pop=1 accepts a pop and goes to RD_SP.
  - push and pop together: push wins and pop is dropped silently.
- **RD_SP:**
  - rb_r_addr=SP_ADDR; rb_busB is captured into sp_q.
  - Push with rb_busB==STACK_FLOOR sets err_q and goes to FIN.
  - Pop with rb_busB==8'hFF sets err_q and goes to FIN.
  - Otherwise goes to PUSH_WR (push) or POP_RD (pop).
- **PUSH_WR:**
  - Memory: mem_we=1, mem_addr=sp_q, mem_wdata=data_q.
  - Bank: rb_w_en=1, rb_w_addr=SP_ADDR, rb_w_data=sp_q-1.
  - Goes to FIN.
- **POP_RD:**
  - Memory read: mem_addr=sp_q+1, mem_we=0.
  - Bank: rb_w_en=1, rb_w_addr=SP_ADDR, rb_w_data=sp_q+1.
  - Goes to POP_WAIT.
- **POP_WAIT:** mem_rdata is captured into pop_data; goes to POP_WB.
- **POP_WB:** rb_w_en=1, rb_w_addr=ACC_ADDR, rb_w_data=pop_data; goes to FIN.
- **FIN:** done=1, err=err_q, ready=0; err_q is cleared; goes to IDLE.
- **Error path:** no bank or memory write occurs and pop_data is unchanged.
- **Arithmetic:** SP arithmetic is modulo 2^DATA_WIDTH. Wrap cannot occur because the floor and empty checks precede every update.
- **Combinational outputs:** rb_w_en and mem_we are decoded from state only and are 0 in every state not listed above. rb_r_addr is 0 outside RD_SP.
- **Reset mid-operation:** the op is aborted immediately and no done pulse is issued. The system reset also resets the register bank, so SP returns to 8'hFF.

## Timing
- Acceptance edge = edge E, when IDLE samples push/pop.
- **Push:** RD_SP in cycle E+1, PUSH_WR in E+2, FIN (done) in E+3, ready again in E+4. Memory and SP writes land at the edge ending E+2.
- **Pop:**
  - RD_SP in E+1, POP_RD in E+2, POP_WAIT in E+3, POP_WB in E+4, FIN in E+5.
  - The SP write lands at the end of E+2 and the ACC write at the end of E+4.
  - pop_data is valid from E+4 onward.
- **Error:** FIN in E+2.
- Requests asserted while ready=0 are ignored; no queueing.
- Back-to-back ops: the earliest next acceptance edge is the end of the cycle after FIN.

## Test plan
- **Reset:** hold rst_n low 2 cycles with the bank's SP at 8'hFF → ready=1, done=0, err=0, rb_w_en=0, mem_we=0, pop_data=0.
- **Push 8'hA5 from SP=8'hFF** → PUSH_WR cycle shows mem_addr=8'hFF, mem_we=1, mem_wdata=8'hA5, and bank write SP=8'hFE. done in E+3, err=0.
- **Push 8'h11 then 8'h22, then two pops** → ACC written 8'h22 then 8'h11, SP sequence FF→FE→FD→FE→FF, and each pop's done lands in E+5.
- **Pop with SP=8'hFF** → err=1 and done=1 in E+2; no rb_w_en or mem_we pulses; pop_data unchanged.
- **Preload SP=8'h80 and push** → overflow: err=1 in E+2; no writes.
- **push=pop=1 in IDLE with SP=8'hFF** → push only; a pop held high during busy cycles is ignored. Separately, drop rst_n during POP_WAIT → IDLE immediately, no ACC write, no done pulse.
